// File: rtl/btc_dec_comp_code_source.sv
// BTC component-code input distribution: column-mode bypass or row-mode vector-to-lane serialiser.
// Optional overrun detection on oerr is built when BTC_DEC_SRC_OVR_CHECK_EN is defined.
module btc_dec_comp_code_source #(
    parameter int unsigned pLLR_W   = 4,
    parameter int unsigned pEXTR_W  = 5,
    parameter int unsigned pDEC_NUM = 8
) (
    input  logic                             iclk,
    input  logic                             ireset,
    input  logic                             iclkena,
    input  logic                             irow_mode,
    input  logic                             ival,
    output logic                             ordy,
    input  logic [4:0]                       istrb,
    input  logic [pDEC_NUM-1:0][pLLR_W-1:0]  iLLR,
    input  logic [pDEC_NUM-1:0][pEXTR_W-1:0] iLextr,
    output logic [pDEC_NUM-1:0]              oval,
    output logic [pDEC_NUM-1:0][4:0]         ostrb,
    output logic [pDEC_NUM-1:0][pLLR_W-1:0]  oLLR,
    output logic [pDEC_NUM-1:0][pEXTR_W-1:0] oLextr,
    output logic                             oerr
);

    // Strobe bit positions: {mask, eof, eop, sop, sof}
    localparam int unsigned StrbSof  = 0;
    localparam int unsigned StrbSop  = 1;
    localparam int unsigned StrbEop  = 2;
    localparam int unsigned StrbEof  = 3;
    localparam int unsigned CntW     = $clog2(pDEC_NUM);
    localparam logic [CntW-1:0] CntLast = CntW'(pDEC_NUM - 1);
    localparam logic [CntW-1:0] CntPen  = CntW'(pDEC_NUM - 2);

    logic [pDEC_NUM-1:0][pDEC_NUM-1:0][pLLR_W-1:0]  llr_sr_q, llr_sr_d;
    logic [pDEC_NUM-1:0][pDEC_NUM-1:0][pEXTR_W-1:0] extr_sr_q, extr_sr_d;
    logic [pDEC_NUM-1:0][4:0]                       strb_q, strb_d;
    logic [pDEC_NUM-1:0][CntW-1:0]                  cnt_q, cnt_d;
    logic [pDEC_NUM-1:0]                            busy_q, busy_d;
    logic [CntW-1:0]                                ptr_q, ptr_d;
    logic                                           mode_q, mode_d;
    logic [pDEC_NUM-1:0]                            oval_q, oval_d;
    logic [pDEC_NUM-1:0][4:0]                       ostrb_q, ostrb_d;
    logic [pDEC_NUM-1:0][pLLR_W-1:0]                ollr_q, ollr_d;
    logic [pDEC_NUM-1:0][pEXTR_W-1:0]               oextr_q, oextr_d;

    logic [CntW-1:0] sel;
    logic            abort;
    logic            accept;

    function automatic logic [4:0] elem_strb(input logic [4:0] s, input logic first,
                                             input logic last);
        logic [4:0] r;
        r          = s;
        r[StrbSof] = s[StrbSof] & first;
        r[StrbSop] = s[StrbSop] & first;
        r[StrbEop] = s[StrbEop] & last;
        r[StrbEof] = s[StrbEof] & last;
        return r;
    endfunction

    assign sel = istrb[StrbSof] ? '0 : ptr_q;

    always_comb begin
        ordy = 1'b1;
        if (irow_mode) begin
            ordy = !busy_q[sel] || (cnt_q[sel] == CntLast);
        end
    end

    // Mode flip with work in flight drops everything, including this cycle's vector
    assign abort  = (irow_mode != mode_q) && (|busy_q);
    assign accept = ival && ordy && !abort;

    always_comb begin
        llr_sr_d  = llr_sr_q;
        extr_sr_d = extr_sr_q;
        strb_d    = strb_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        mode_d    = irow_mode;
        oval_d    = oval_q;
        ostrb_d   = ostrb_q;
        ollr_d    = ollr_q;
        oextr_d   = oextr_q;

        if (abort) begin
            busy_d = '0;
            oval_d = '0;
            ptr_d  = '0;
        end else if (!irow_mode) begin
            for (int g = 0; g < pDEC_NUM; g++) begin
                oval_d[g]  = ival;
                ostrb_d[g] = istrb;
                ollr_d[g]  = iLLR[g];
                oextr_d[g] = iLextr[g];
            end
        end else begin
            for (int g = 0; g < pDEC_NUM; g++) begin
                oval_d[g] = 1'b0;
                if (busy_q[g]) begin
                    if (cnt_q[g] == CntLast) begin
                        busy_d[g] = 1'b0;
                    end else begin
                        cnt_d[g]   = cnt_q[g] + 1'b1;
                        oval_d[g]  = 1'b1;
                        ollr_d[g]  = llr_sr_q[g][0];
                        oextr_d[g] = extr_sr_q[g][0];
                        ostrb_d[g] = elem_strb(strb_q[g], 1'b0, cnt_q[g] == CntPen);
                        for (int k = 0; k < pDEC_NUM - 1; k++) begin
                            llr_sr_d[g][k]  = llr_sr_q[g][k+1];
                            extr_sr_d[g][k] = extr_sr_q[g][k+1];
                        end
                    end
                end
                // Element 0 goes straight to the outputs; the rest wait in the shift register
                if (accept && (sel == CntW'(g))) begin
                    busy_d[g]  = 1'b1;
                    cnt_d[g]   = '0;
                    strb_d[g]  = istrb;
                    oval_d[g]  = 1'b1;
                    ollr_d[g]  = iLLR[0];
                    oextr_d[g] = iLextr[0];
                    ostrb_d[g] = elem_strb(istrb, 1'b1, 1'b0);
                    for (int k = 0; k < pDEC_NUM - 1; k++) begin
                        llr_sr_d[g][k]  = iLLR[k+1];
                        extr_sr_d[g][k] = iLextr[k+1];
                    end
                end
            end
            if (accept) begin
                ptr_d = sel + 1'b1;
            end
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            llr_sr_q  <= '0;
            extr_sr_q <= '0;
            strb_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= '0;
            ptr_q     <= '0;
            mode_q    <= 1'b0;
            oval_q    <= '0;
            ostrb_q   <= '0;
            ollr_q    <= '0;
            oextr_q   <= '0;
        end else if (iclkena) begin
            llr_sr_q  <= llr_sr_d;
            extr_sr_q <= extr_sr_d;
            strb_q    <= strb_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            mode_q    <= mode_d;
            oval_q    <= oval_d;
            ostrb_q   <= ostrb_d;
            ollr_q    <= ollr_d;
            oextr_q   <= oextr_d;
        end
    end

    assign oval   = oval_q;
    assign ostrb  = ostrb_q;
    assign oLLR   = ollr_q;
    assign oLextr = oextr_q;

`ifdef BTC_DEC_SRC_OVR_CHECK_EN
    logic oerr_q, oerr_d;

    always_comb begin
        oerr_d = oerr_q;
        if (ival && !ordy && irow_mode) begin
            oerr_d = 1'b1;
        end else if (accept && istrb[StrbSof]) begin
            oerr_d = 1'b0;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oerr_q <= 1'b0;
        end else if (iclkena) begin
            oerr_q <= oerr_d;
        end
    end

    assign oerr = oerr_q;
`else
    assign oerr = 1'b0;
`endif

endmodule

// File: tb/tb_btc_dec_comp_code_source.sv
// Bench for btc_dec_comp_code_source: table vectors, directed multi-cycle sequences and
// random stimulus against a queue-based lane model.
module tb_btc_dec_comp_code_source;
    localparam int N  = 8;
    localparam int LW = 4;
    localparam int EW = 5;

    logic                 iclk = 1'b0;
    logic                 ireset, iclkena, irow_mode, ival, ordy, oerr;
    logic [4:0]           istrb;
    logic [N-1:0][LW-1:0] iLLR, oLLR;
    logic [N-1:0][EW-1:0] iLextr, oLextr;
    logic [N-1:0]         oval;
    logic [N-1:0][4:0]    ostrb;

    always #5 iclk = ~iclk;

    btc_dec_comp_code_source #(.pLLR_W(LW), .pEXTR_W(EW), .pDEC_NUM(N)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .irow_mode(irow_mode),
        .ival(ival), .ordy(ordy), .istrb(istrb), .iLLR(iLLR), .iLextr(iLextr),
        .oval(oval), .ostrb(ostrb), .oLLR(oLLR), .oLextr(oLextr), .oerr(oerr)
    );

    int checks = 0;
    int errors = 0;
    logic last_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane model: each lane is a queue of elements still to appear after the one shown now
    typedef struct packed {
        logic [4:0]    s;
        logic [LW-1:0] l;
        logic [EW-1:0] e;
    } elem_t;

    elem_t    pend [N][$];
    elem_t    m_out [N];
    logic [N-1:0] m_val;
    int       m_ptr;
    logic     m_mode, m_err;

    task automatic m_reset();
        for (int g = 0; g < N; g++) begin
            pend[g].delete();
            m_out[g] = '0;
        end
        m_val = '0; m_ptr = 0; m_mode = 1'b0; m_err = 1'b0;
    endtask

    function automatic int m_sel();
        return istrb[0] ? 0 : m_ptr;
    endfunction

    function automatic logic m_rdy();
        if (!irow_mode) return 1'b1;
        return pend[m_sel()].size() == 0;
    endfunction

    function automatic logic [4:0] k_strb(input logic [4:0] s, input int k);
        logic [4:0] r;
        r = s;
        if (k != 0) begin r[0] = 1'b0; r[1] = 1'b0; end
        if (k != N - 1) begin r[2] = 1'b0; r[3] = 1'b0; end
        return r;
    endfunction

    task automatic m_step();
        int    sel;
        logic  rdy, abort, acc;
        elem_t e;
        if (!iclkena) return;
        sel   = m_sel();
        rdy   = m_rdy();
        abort = m_mode && !irow_mode && (m_val != '0);
        acc   = ival && rdy && !abort;
`ifdef BTC_DEC_SRC_OVR_CHECK_EN
        if (irow_mode && ival && !rdy) m_err = 1'b1;
        else if (acc && istrb[0]) m_err = 1'b0;
`endif
        if (abort) begin
            for (int g = 0; g < N; g++) pend[g].delete();
            m_val = '0;
            m_ptr = 0;
        end else if (!irow_mode) begin
            for (int g = 0; g < N; g++) begin
                m_val[g] = ival;
                m_out[g] = {istrb, iLLR[g], iLextr[g]};
            end
        end else begin
            for (int g = 0; g < N; g++) begin
                if (pend[g].size() > 0) begin
                    m_out[g] = pend[g].pop_front();
                    m_val[g] = 1'b1;
                end else begin
                    m_val[g] = 1'b0;
                end
            end
            if (acc) begin
                for (int k = 0; k < N; k++) begin
                    e = {k_strb(istrb, k), iLLR[k], iLextr[k]};
                    if (k == 0) begin
                        m_out[sel] = e;
                        m_val[sel] = 1'b1;
                    end else begin
                        pend[sel].push_back(e);
                    end
                end
                m_ptr = (sel + 1) % N;
            end
        end
        m_mode = irow_mode;
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0][4:0]    es;
        logic [N-1:0][LW-1:0] el;
        logic [N-1:0][EW-1:0] ee;
        for (int g = 0; g < N; g++) begin
            es[g] = m_out[g].s; el[g] = m_out[g].l; ee[g] = m_out[g].e;
        end
        chk({tag, " oval"}, 64'(oval), 64'(m_val));
        chk({tag, " ostrb"}, 64'(ostrb), 64'(es));
        chk({tag, " oLLR"}, 64'(oLLR), 64'(el));
        chk({tag, " oLextr"}, 64'(oLextr), 64'(ee));
        chk({tag, " oerr"}, 64'(oerr), 64'(m_err));
    endtask

    // Entered at posedge+1 with inputs already set; leaves at the next posedge+1
    task automatic cycle(input string tag);
        #2;
        last_rdy = ordy;
        chk({tag, " ordy"}, 64'(ordy), 64'(m_rdy()));
        m_step();
        @(posedge iclk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input int n);
        ival = 1'b0;
        for (int i = 0; i < n; i++) cycle("idle");
    endtask

    function automatic logic [LW-1:0] pat_llr(input int c, input int k);
        return LW'((c * 5 + k) % 16);
    endfunction

    task automatic set_vec(input int c);
        for (int k = 0; k < N; k++) begin
            iLLR[k]   = pat_llr(c, k);
            iLextr[k] = EW'((c * 3 + k + 1) % 32);
        end
    endtask

    function automatic logic [N-1:0] t2_mask(input int e);
        logic [N-1:0] m;
        m = '0;
        for (int g = 0; g < N; g++) m[g] = (g < e) && (e <= g + N);
        return m;
    endfunction

    typedef struct {
        logic         ival;
        logic [4:0]   strb;
        logic [31:0]  llr;
        logic [39:0]  extr;
        logic [7:0]   exp_val;
        logic [4:0]   exp_strb;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int   held;

        tbl[0] = '{ival: 1'b1, strb: 5'b00101, llr: 32'h76543210, extr: 40'h0123456789,
                   exp_val: 8'hFF, exp_strb: 5'b00101};
        tbl[1] = '{ival: 1'b0, strb: 5'b00000, llr: 32'hFFFFFFFF, extr: 40'h0,
                   exp_val: 8'h00, exp_strb: 5'b00000};
        tbl[2] = '{ival: 1'b1, strb: 5'b11010, llr: 32'hA5A55A5A, extr: 40'hFEDCBA9876,
                   exp_val: 8'hFF, exp_strb: 5'b11010};
        tbl[3] = '{ival: 1'b1, strb: 5'b10000, llr: 32'h0F0F0F0F, extr: 40'h8421084210,
                   exp_val: 8'hFF, exp_strb: 5'b10000};

        ireset = 1'b1; iclkena = 1'b1; irow_mode = 1'b0; ival = 1'b0;
        istrb = '0; iLLR = '0; iLextr = '0;
        m_reset();
        repeat (2) @(posedge iclk);
        #1;
        chk("reset oval", 64'(oval), 64'(0));
        chk("reset ostrb", 64'(ostrb), 64'(0));
        chk("reset oLLR", 64'(oLLR), 64'(0));
        chk("reset oLextr", 64'(oLextr), 64'(0));
        chk("reset oerr", 64'(oerr), 64'(0));
        chk("reset ordy", 64'(ordy), 64'(1));
        ireset = 1'b0;

        // Column-mode bypass vectors
        for (int i = 0; i < 4; i++) begin
            ival = tbl[i].ival; istrb = tbl[i].strb;
            iLLR = tbl[i].llr; iLextr = tbl[i].extr;
            cycle("t1");
            chk("t1 ordy", 64'(last_rdy), 64'(1));
            chk("t1 oval", 64'(oval), 64'(tbl[i].exp_val));
            chk("t1 oLLR", 64'(oLLR), 64'(tbl[i].llr));
            chk("t1 oLextr", 64'(oLextr), 64'(tbl[i].extr));
            chk("t1 ostrb0", 64'(ostrb[0]), 64'(tbl[i].exp_strb));
            chk("t1 ostrb7", 64'(ostrb[7]), 64'(tbl[i].exp_strb));
        end

        // Eight back-to-back row vectors, one per lane
        irow_mode = 1'b1;
        for (int t = 0; t < 18; t++) begin
            if (t < N) begin
                set_vec(t); ival = 1'b1;
                istrb = (t == 0) ? 5'b00111 : 5'b00110;
            end else begin
                ival = 1'b0;
            end
            cycle("t2");
            if (t < N) chk("t2 ordy", 64'(last_rdy), 64'(1));
            chk("t2 oval", 64'(oval), 64'(t2_mask(t + 1)));
            if (t < N) chk("t2 lane0 llr", 64'(oLLR[0]), 64'(pat_llr(0, t)));
            if (t == 0) chk("t2 sof", 64'(ostrb[0][0]), 64'(1));
            if (t == 7) chk("t2 eop", 64'(ostrb[0][2]), 64'(1));
        end

        // Sixteen continuous vectors: lane 0 reloads without a bubble
        for (int t = 0; t < 20; t++) begin
            if (t < 16) begin
                set_vec(t + 20); ival = 1'b1;
                istrb = (t == 0) ? 5'b00111 : 5'b00110;
            end else begin
                ival = 1'b0;
            end
            cycle("t3");
            if (t < 16) chk("t3 ordy", 64'(last_rdy), 64'(1));
            chk("t3 oval0", 64'(oval[0]), 64'((t + 1) <= 16));
            if (t == 8) chk("t3 reload llr", 64'(oLLR[0]), 64'(pat_llr(28, 0)));
        end
        idle(6);

        // New sof vector offered while lane 0 is at element 3
        set_vec(40); istrb = 5'b00011; ival = 1'b1;
        cycle("t4 v0");
        ival = 1'b0;
        repeat (3) cycle("t4 stall");
        set_vec(41); istrb = 5'b00011; ival = 1'b1;
        held = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("t4 offer");
            if (last_rdy) break;
            held++;
`ifdef BTC_DEC_SRC_OVR_CHECK_EN
            chk("t4 oerr set", 64'(oerr), 64'(1));
`endif
        end
        chk("t4 held cycles", 64'(held), 64'(4));
        chk("t4 accepted llr", 64'(oLLR[0]), 64'(pat_llr(41, 0)));
        chk("t4 accepted val", 64'(oval[0]), 64'(1));
        chk("t4 oerr clear", 64'(oerr), 64'(0));
        idle(10);

        // Mode toggle with lanes 2..5 busy
        for (int c = 0; c < 6; c++) begin
            set_vec(50 + c); istrb = (c == 0) ? 5'b00011 : 5'b00000; ival = 1'b1;
            cycle("t5 load");
        end
        ival = 1'b0;
        repeat (4) cycle("t5 run");
        chk("t5 busy lanes", 64'(oval), 64'(8'b0011_1100));
        irow_mode = 1'b0; set_vec(60); istrb = '0; ival = 1'b1;
        cycle("t5 abort");
        chk("t5 abort oval", 64'(oval), 64'(0));
        irow_mode = 1'b1; set_vec(61); istrb = '0; ival = 1'b1;
        cycle("t5 reload");
        chk("t5 lane0 only", 64'(oval), 64'(8'h01));
        chk("t5 lane0 llr", 64'(oLLR[0]), 64'(pat_llr(61, 0)));
        idle(10);

        // Clock-enable freeze mid-row, then asynchronous reset
        set_vec(9); istrb = 5'b00011; ival = 1'b1;
        cycle("t6 load");
        ival = 1'b0;
        repeat (2) cycle("t6 run");
        chk("t6 elem2", 64'(oLLR[0]), 64'(pat_llr(9, 2)));
        iclkena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("t6 frozen");
            chk("t6 frozen llr", 64'(oLLR[0]), 64'(pat_llr(9, 2)));
            chk("t6 frozen val", 64'(oval), 64'(8'h01));
        end
        iclkena = 1'b1;
        for (int k = 3; k < 6; k++) begin
            cycle("t6 resume");
            chk("t6 resume llr", 64'(oLLR[0]), 64'(pat_llr(9, k)));
        end
        ival = 1'b1; istrb = 5'b00011;
        ireset = 1'b1;
        #2;
        chk("t6 rst oval", 64'(oval), 64'(0));
        chk("t6 rst oLLR", 64'(oLLR), 64'(0));
        chk("t6 rst ostrb", 64'(ostrb), 64'(0));
        chk("t6 rst oLextr", 64'(oLextr), 64'(0));
        chk("t6 rst ordy", 64'(ordy), 64'(1));
        m_reset();
        @(posedge iclk);
        #1;
        ireset = 1'b0;
        check_outputs("t6 post reset");

        // Random traffic against the lane model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(39) == 0) irow_mode = ~irow_mode;
            iclkena = ($urandom_range(9) != 0);
            ival    = ($urandom_range(3) != 0);
            istrb   = 5'($urandom());
            istrb[0] = ($urandom_range(11) == 0);
            iLLR    = $urandom();
            iLextr  = {8'($urandom()), $urandom()};
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
